video_ts_dram_arb: RTL
======================

// Module: video_ts_dram_arb
// PURPOSE
//  Arbitrates the single TS DRAM read port between two requesters:
//  - tilemap prefetch (TM)
//  - the tile/sprite renderer graphics fetch (RN)
//  Grants whole bursts, alternating round-robin at burst boundaries.
//  Enforces a per-video-line DRAM word budget so TS traffic cannot starve other video fetch.
//  Sits between the TS unit / TS renderer and the video DRAM mux.
// PARAMETERS
//  BURST    8   max words per grant before re-arbitration (power of 2, >=2)
//  ADDR_W   21  DRAM word address width
//  BUDG_W   10  width of per-line word budget
// PORTS
//  clk            in   1        system clock, all logic on rising edge
//  rst_n          in   1        asynchronous active-low reset
//  line_start     in   1        1-cycle pulse at start of each video line
//  slot_budget    in   BUDG_W   DRAM words TS may read this line (sampled at line_start)
//  tm_req         in   1        TM wants a word
//  tm_addr        in   ADDR_W   TM word address
//  tm_next        out  1        TM word delivered this cycle (data on DRAM read bus)
//  rn_req         in   1        RN wants a word
//  rn_addr        in   ADDR_W   RN word address
//  rn_next        out  1        RN word delivered this cycle
//  dram_req       out  1        request to DRAM controller
//  dram_addr      out  ADDR_W   address to DRAM controller
//  dram_next      in   1        DRAM accepted/returned word for current request
//  grant          out  2        {RN,TM} one-hot current owner, 00 = none
//  budget_empty   out  1        budget counter == 0
// BEHAVIOUR
//  State machine:
//   IDLE -> TM_BURST / RN_BURST (registered grant, 1-cycle arbitration latency)
//   BURST -> IDLE on burst end
//   any -> STARVED when budget hits 0
//   STARVED -> IDLE only on line_start with slot_budget != 0
//  Arbitration in IDLE, budget != 0:
//   - only one req high: grant it
//   - both high: grant the one NOT granted last (last_grant reg)
//   - last_grant resets to RN, so TM wins first contention
//  Request/address:
//   - dram_req = owner_req && (budget != 0), combinational
//   - dram_addr = owner addr; 0 when grant = 00
//  Word delivery (xfer = dram_next && dram_req):
//   - tm_next = xfer && grant[0]; rn_next = xfer && grant[1]
//   - dram_next while dram_req = 0: ignored, not forwarded, not counted
//  Burst end: BURST xfers counted (counter wraps to 0) OR owner req sampled low.
//   - next state IDLE, grant -> 00, last_grant updated
//   - no back-to-back grant without one IDLE cycle
//  Budget:
//   - line_start loads slot_budget, else decrements by 1 on each xfer
//   - never underflows
//   - reaching 0 forces STARVED, grant 00, dram_req 0
//  line_start mid-burst:
//   - burst aborted, state IDLE, burst counter cleared, budget reloaded
//   - an xfer in the same cycle is still forwarded but not counted
//   - slot_budget = 0 at line_start: STARVED immediately
//  Reset values:
//   - state STARVED, grant 00, budget 0, burst count 0, last_grant RN
//   - dram_req 0, tm_next 0, rn_next 0, dram_addr 0, budget_empty 1
//   - no grants until first line_start
// TESTING
//  1. line_start(budget=100), tm_req held, dram_next every cycle
//     -> grant=01 at cycle+1; 8 tm_next pulses; 1 IDLE cycle; re-grant TM; budget 84 after 2 bursts.
//  2. both req held, budget=32, dram_next always 1
//     -> bursts TM,RN,TM,RN of 8 words each; budget_empty=1 after 32nd word; dram_req=0 until next line_start.
//  3. RN drops req after 3 words
//     -> burst ends, grant 00 next cycle; pending tm_req granted the following cycle; budget decremented by 3 only.
//  4. line_start(budget=50) during TM word 5 of burst
//     -> word 5 forwarded, not counted; IDLE next cycle; budget=50; fresh arbitration.
//  5. dram_next pulsed while dram_req=0 (grant 00 and STARVED)
//     -> no tm_next/rn_next, budget unchanged.
//  6. Assert rst_n low mid-burst
//     -> all outputs immediately at reset values; line_start(budget=0) -> stays STARVED, dram_req never 1.

Source files
------------

// File: rtl/video_ts_dram_arb.sv
// video_ts_dram_arb: shares the TS DRAM read port between tilemap prefetch
// (TM) and the renderer graphics fetch (RN). It grants whole bursts,
// alternates round-robin at burst boundaries and enforces a per-line word budget.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   line_start            1-cycle pulse at start of each video line
//   slot_budget           words TS may read this line (sampled at line_start)
//   tm_req/tm_addr        tilemap prefetch request and word address
//   tm_next               TM word delivered this cycle
//   rn_req/rn_addr        renderer request and word address
//   rn_next               RN word delivered this cycle
//   dram_req/dram_addr    request to the video DRAM mux
//   dram_next             DRAM accepted/returned the current word
//   grant                 {RN,TM} one-hot owner, 00 = none
//   budget_empty          per-line budget exhausted
module video_ts_dram_arb #(
    parameter int BURST  = 8,
    parameter int ADDR_W = 21,
    parameter int BUDG_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [BUDG_W-1:0] slot_budget,
    input  logic              tm_req,
    input  logic [ADDR_W-1:0] tm_addr,
    output logic              tm_next,
    input  logic              rn_req,
    input  logic [ADDR_W-1:0] rn_addr,
    output logic              rn_next,
    output logic              dram_req,
    output logic [ADDR_W-1:0] dram_addr,
    input  logic              dram_next,
    output logic [1:0]        grant,
    output logic              budget_empty
);

    localparam int CW = $clog2(BURST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TM,
        ST_RN,
        ST_STARVED
    } state_t;

    state_t            state, state_n;
    logic [BUDG_W-1:0] budget, budget_n;
    logic [CW-1:0]     bcnt, bcnt_n;
    logic              last_rn, last_rn_n;

    logic              in_burst;
    logic              owner_req;
    logic              xfer;
    logic              burst_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_STARVED;
            budget  <= '0;
            bcnt    <= '0;
            last_rn <= 1'b1;
        end else begin
            state   <= state_n;
            budget  <= budget_n;
            bcnt    <= bcnt_n;
            last_rn <= last_rn_n;
        end
    end

    assign grant        = {state == ST_RN, state == ST_TM};
    assign in_burst     = (state == ST_TM) || (state == ST_RN);
    assign owner_req    = ((state == ST_TM) && tm_req) ||
                          ((state == ST_RN) && rn_req);
    assign budget_empty = (budget == '0);
    assign dram_req     = owner_req && !budget_empty;
    assign xfer         = dram_next && dram_req;
    assign tm_next      = xfer && grant[0];
    assign rn_next      = xfer && grant[1];

    always_comb begin
        dram_addr = '0;
        if (state == ST_TM) begin
            dram_addr = tm_addr;
        end else if (state == ST_RN) begin
            dram_addr = rn_addr;
        end
    end

    // A burst closes after BURST counted words or as soon as the owner
    // stops asking; a dropped request never holds the port.
    assign burst_end = in_burst &&
                       (!owner_req || (xfer && (bcnt == CW'(BURST - 1))));

    always_comb begin
        state_n   = state;
        budget_n  = budget;
        bcnt_n    = bcnt;
        last_rn_n = last_rn;

        if (line_start) begin
            // New line wins over everything: the word moving this cycle is
            // still delivered but charged to nobody.
            budget_n = slot_budget;
            bcnt_n   = '0;
            if (in_burst) begin
                last_rn_n = (state == ST_RN);
            end
            state_n = (slot_budget == '0) ? ST_STARVED : ST_IDLE;
        end else begin
            if (xfer) begin
                budget_n = budget - BUDG_W'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    if (tm_req && (!rn_req || last_rn)) begin
                        state_n = ST_TM;
                    end else if (rn_req) begin
                        state_n = ST_RN;
                    end
                end
                ST_TM, ST_RN: begin
                    if (burst_end) begin
                        state_n   = ST_IDLE;
                        bcnt_n    = '0;
                        last_rn_n = (state == ST_RN);
                    end else if (xfer) begin
                        bcnt_n = bcnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase

            // Running dry overrides any arbitration or burst outcome.
            if (budget_n == '0) begin
                state_n = ST_STARVED;
                bcnt_n  = '0;
                if (in_burst) begin
                    last_rn_n = (state == ST_RN);
                end
            end
        end
    end

endmodule
